// File: rtl/ft_shadow_recovery_if.sv
// Writeback-compare, debug-port and status bundle between the lockstep wrapper
// and the shadow-recovery unit.
interface ft_shadow_recovery_if;
  logic        we_a_i;
  logic        we_b_i;
  logic [4:0]  addr_a_i;
  logic [4:0]  addr_b_i;
  logic [31:0] data_a_i;
  logic [31:0] data_b_i;
  logic [31:0] pc_i;
  logic        halted_i;
  logic        halt_o;
  logic        resume_o;
  logic        dbg_we_o;
  logic [14:0] dbg_addr_o;
  logic [31:0] dbg_wdata_o;
  logic        core_rst_no;
  logic        busy_o;
  logic        fatal_o;
  logic [15:0] err_cnt_o;

  modport master (
    output we_a_i, we_b_i, addr_a_i, addr_b_i, data_a_i, data_b_i, pc_i, halted_i,
    input  halt_o, resume_o, dbg_we_o, dbg_addr_o, dbg_wdata_o,
    input  core_rst_no, busy_o, fatal_o, err_cnt_o
  );

  modport slave (
    input  we_a_i, we_b_i, addr_a_i, addr_b_i, data_a_i, data_b_i, pc_i, halted_i,
    output halt_o, resume_o, dbg_we_o, dbg_addr_o, dbg_wdata_o,
    output core_rst_no, busy_o, fatal_o, err_cnt_o
  );
endinterface

// File: rtl/ft_shadow_recovery.sv
// Lockstep writeback comparator with a shadow GPR file; on divergence it halts
// both cores, replays agreed GPRs and PC over the debug port, then resumes.
module ft_shadow_recovery #(
  parameter int          NREGS    = 32,
  parameter logic [14:0] GPR_BASE = 15'h0400,
  parameter logic [14:0] NPC_ADDR = 15'h2000,
  parameter int          HALT_TMO = 64
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  ft_shadow_recovery_if.slave bus
);

  localparam int IDX_W = $clog2(NREGS);
  localparam int TMO_W = $clog2(HALT_TMO + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HALT_TMO - 1);
  localparam logic [5:0]       NREGS_W  = 6'(NREGS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HALT   = 3'd1,
    S_GPR    = 3'd2,
    S_NPC    = 3'd3,
    S_RESUME = 3'd4,
    S_RUN    = 3'd5,
    S_FATAL  = 3'd6
  } state_e;

  state_e           state_r, state_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [TMO_W-1:0] tmo_r, tmo_s;
  logic [31:0]      shadow_r [NREGS];
  logic [31:0]      spc_r;
  logic             mismatch_s;
  logic             shadow_we_s;
  logic             spc_we_s;

  logic             halt_r, halt_s;
  logic             resume_r, resume_s;
  logic             dbg_we_r, dbg_we_s;
  logic [14:0]      dbg_addr_r, dbg_addr_s;
  logic [31:0]      dbg_wdata_r, dbg_wdata_s;
  logic             core_rst_n_r, core_rst_n_s;
  logic             busy_r, busy_s;
  logic             fatal_r, fatal_s;
  logic [15:0]      err_cnt_r, err_cnt_s;

  // Stream compare and shadow/PC capture enables (only meaningful in IDLE).
  always_comb begin
    mismatch_s  = (bus.we_a_i != bus.we_b_i) |
                  (bus.we_a_i & ((bus.addr_a_i != bus.addr_b_i) |
                                 (bus.data_a_i != bus.data_b_i)));
    shadow_we_s = 1'b0;
    spc_we_s    = 1'b0;
    if ((state_r == S_IDLE) && !mismatch_s) begin
      spc_we_s    = 1'b1;
      shadow_we_s = bus.we_a_i && (bus.addr_a_i != 5'd0) &&
                    ({1'b0, bus.addr_a_i} < NREGS_W);
    end else begin
      spc_we_s    = 1'b0;
      shadow_we_s = 1'b0;
    end
  end

  // Recovery FSM next-state, replay index and timeout counter.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    tmo_s   = tmo_r;
    case (state_r)
      S_IDLE: begin
        if (mismatch_s) begin
          state_s = S_HALT;
          tmo_s   = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_HALT: begin
        if (bus.halted_i) begin
          state_s = S_GPR;
          idx_s   = IDX_W'(1);
        end else if (tmo_r == TMO_LAST) begin
          state_s = S_FATAL;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      S_GPR: begin
        if (!bus.halted_i) begin
          state_s = S_HALT;
          idx_s   = IDX_W'(1);
          tmo_s   = '0;
        end else if (idx_r == LAST_IDX) begin
          state_s = S_NPC;
        end else begin
          idx_s = idx_r + IDX_W'(1);
        end
      end
      S_NPC: begin
        if (!bus.halted_i) begin
          state_s = S_HALT;
          idx_s   = IDX_W'(1);
          tmo_s   = '0;
        end else begin
          state_s = S_RESUME;
        end
      end
      S_RESUME: begin
        state_s = S_RUN;
        tmo_s   = '0;
      end
      S_RUN: begin
        if (!bus.halted_i) begin
          state_s = S_IDLE;
        end else if (tmo_r == TMO_LAST) begin
          state_s = S_FATAL;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      S_FATAL: begin
        state_s = S_FATAL;
      end
      default: begin
        state_s = S_FATAL;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so every port is a flop.
  always_comb begin
    halt_s       = (state_s == S_HALT) || (state_s == S_GPR) || (state_s == S_NPC);
    resume_s     = (state_s == S_RESUME);
    core_rst_n_s = (state_s != S_FATAL);
    fatal_s      = (state_s == S_FATAL);
    busy_s       = (state_s != S_IDLE);
    dbg_we_s     = 1'b0;
    dbg_addr_s   = 15'd0;
    dbg_wdata_s  = 32'd0;
    if (state_s == S_GPR) begin
      dbg_we_s    = 1'b1;
      dbg_addr_s  = GPR_BASE + 15'({idx_s, 2'b00});
      dbg_wdata_s = shadow_r[idx_s];
    end else if (state_s == S_NPC) begin
      dbg_we_s    = 1'b1;
      dbg_addr_s  = NPC_ADDR;
      dbg_wdata_s = spc_r;
    end else begin
      dbg_we_s    = 1'b0;
      dbg_addr_s  = 15'd0;
      dbg_wdata_s = 32'd0;
    end
  end

  // Saturating divergence counter, stepped on each IDLE->HALT transition.
  always_comb begin
    err_cnt_s = err_cnt_r;
    if ((state_r == S_IDLE) && (state_s == S_HALT) && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_s = err_cnt_r + 16'd1;
    end else begin
      err_cnt_s = err_cnt_r;
    end
  end

  // FSM state, replay index and timeout registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= S_IDLE;
      idx_r   <= '0;
      tmo_r   <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      tmo_r   <= tmo_s;
    end
  end

  // Shadow GPR file and last agreed PC.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) begin
        shadow_r[i] <= 32'd0;
      end
      spc_r <= 32'd0;
    end else begin
      if (shadow_we_s) begin
        shadow_r[bus.addr_a_i[IDX_W-1:0]] <= bus.data_a_i;
      end
      if (spc_we_s) begin
        spc_r <= bus.pc_i;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      halt_r       <= 1'b0;
      resume_r     <= 1'b0;
      dbg_we_r     <= 1'b0;
      dbg_addr_r   <= 15'd0;
      dbg_wdata_r  <= 32'd0;
      core_rst_n_r <= 1'b1;
      busy_r       <= 1'b0;
      fatal_r      <= 1'b0;
      err_cnt_r    <= 16'd0;
    end else begin
      halt_r       <= halt_s;
      resume_r     <= resume_s;
      dbg_we_r     <= dbg_we_s;
      dbg_addr_r   <= dbg_addr_s;
      dbg_wdata_r  <= dbg_wdata_s;
      core_rst_n_r <= core_rst_n_s;
      busy_r       <= busy_s;
      fatal_r      <= fatal_s;
      err_cnt_r    <= err_cnt_s;
    end
  end

  assign bus.halt_o      = halt_r;
  assign bus.resume_o    = resume_r;
  assign bus.dbg_we_o    = dbg_we_r;
  assign bus.dbg_addr_o  = dbg_addr_r;
  assign bus.dbg_wdata_o = dbg_wdata_r;
  assign bus.core_rst_no = core_rst_n_r;
  assign bus.busy_o      = busy_r;
  assign bus.fatal_o     = fatal_r;
  assign bus.err_cnt_o   = err_cnt_r;

endmodule

// File: tb/tb_ft_shadow_recovery.sv
// Directed scoreboard bench for ft_shadow_recovery: expected debug writes are
// queued from a local shadow model and popped as the DUT emits them.
module tb_ft_shadow_recovery;

  localparam int NREGS = 32;

  typedef struct packed {
    logic [14:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] sh [NREGS];
  logic [31:0] spc;
  wr_t         exp_q [$];

  always #5 clk_i = ~clk_i;

  ft_shadow_recovery_if bus ();

  ft_shadow_recovery #(
    .NREGS(32), .GPR_BASE(15'h0400), .NPC_ADDR(15'h2000), .HALT_TMO(64)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_halt"},     32'(bus.halt_o),      32'd0);
    chk({tag, "_resume"},   32'(bus.resume_o),    32'd0);
    chk({tag, "_dbg_we"},   32'(bus.dbg_we_o),    32'd0);
    chk({tag, "_dbg_addr"}, 32'(bus.dbg_addr_o),  32'd0);
    chk({tag, "_dbg_data"}, bus.dbg_wdata_o,      32'd0);
    chk({tag, "_core_rst"}, 32'(bus.core_rst_no), 32'd1);
    chk({tag, "_busy"},     32'(bus.busy_o),      32'd0);
    chk({tag, "_fatal"},    32'(bus.fatal_o),     32'd0);
    chk({tag, "_err_cnt"},  32'(bus.err_cnt_o),   32'd0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) sh[i] = 32'd0;
    spc = 32'd0;
  endtask

  // Agreed write in IDLE; updates the bench model the way the shadow file should.
  task automatic wb(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus.we_a_i = 1'b1;  bus.we_b_i = 1'b1;
    bus.addr_a_i = a;   bus.addr_b_i = a;
    bus.data_a_i = d;   bus.data_b_i = d;
    bus.pc_i = pc;
    tick();
    if (a != 5'd0) sh[a] = d;
    spc = pc;
    bus.we_a_i = 1'b0;  bus.we_b_i = 1'b0;
  endtask

  // Divergent cycle in IDLE; the model is deliberately left untouched.
  task automatic mis(input logic we_b, input logic [4:0] a, input logic [31:0] da,
                     input logic [31:0] db, input logic [31:0] pc);
    bus.we_a_i = 1'b1;  bus.we_b_i = we_b;
    bus.addr_a_i = a;   bus.addr_b_i = a;
    bus.data_a_i = da;  bus.data_b_i = db;
    bus.pc_i = pc;
    tick();
    bus.we_a_i = 1'b0;  bus.we_b_i = 1'b0;
  endtask

  task automatic push_gprs(input int last);
    wr_t w;
    for (int i = 1; i <= last; i++) begin
      w.addr = 15'h0400 + 15'(i * 4);
      w.data = sh[i];
      exp_q.push_back(w);
    end
  endtask

  task automatic push_npc();
    wr_t w;
    w.addr = 15'h2000;
    w.data = spc;
    exp_q.push_back(w);
  endtask

  // Pops one expected write per observed dbg_we_o; stops on the last write without ticking past it.
  task automatic drain(input string tag, input int max);
    int  n = 0;
    wr_t w;
    while ((exp_q.size() > 0) && (n < max)) begin
      if (bus.dbg_we_o === 1'b1) begin
        w = exp_q.pop_front();
        chk({tag, "_addr"}, 32'(bus.dbg_addr_o), 32'(w.addr));
        chk({tag, "_data"}, bus.dbg_wdata_o, w.data);
        if (exp_q.size() > 0) tick();
      end else begin
        tick();
      end
      n++;
    end
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_ni = 1'b0;
    bus.we_a_i = 1'b0;  bus.we_b_i = 1'b0;
    bus.addr_a_i = 5'd0; bus.addr_b_i = 5'd0;
    bus.data_a_i = 32'd0; bus.data_b_i = 32'd0;
    bus.pc_i = 32'd0;   bus.halted_i = 1'b0;
    model_clear();
    tick();
    tick();
    check_reset("reset");
    rst_ni = 1'b1;
    tick();

    // Agreed writes, including a dropped x0 write.
    wb(5'd5,  32'h0000_1234, 32'h0000_0100);
    wb(5'd0,  32'h0000_FFFF, 32'h0000_0104);
    wb(5'd1,  32'hA5A5_0001, 32'h0000_0108);
    wb(5'd31, 32'hDEAD_BEEF, 32'h0000_010C);
    wb(5'd7,  32'h0707_0707, 32'h0000_0110);
    tick();
    chk("agree_halt", 32'(bus.halt_o), 32'd0);
    chk("agree_busy", 32'(bus.busy_o), 32'd0);

    // Data divergence on x7: halt on the next cycle, x7 keeps its old shadow value.
    mis(1'b1, 5'd7, 32'h0000_7777, 32'h0000_7778, 32'h0000_0200);
    chk("div_halt",   32'(bus.halt_o),    32'd1);
    chk("div_err",    32'(bus.err_cnt_o), 32'd1);
    chk("div_busy",   32'(bus.busy_o),    32'd1);
    chk("div_dbg_we", 32'(bus.dbg_we_o),  32'd0);
    tick();
    tick();
    bus.halted_i = 1'b1;
    push_gprs(NREGS - 1);
    push_npc();
    drain("rec1", 200);
    tick();
    chk("rec1_resume",   32'(bus.resume_o), 32'd1);
    chk("rec1_halt_off", 32'(bus.halt_o),   32'd0);
    chk("rec1_we_off",   32'(bus.dbg_we_o), 32'd0);
    tick();
    chk("rec1_resume_1cyc", 32'(bus.resume_o), 32'd0);
    chk("rec1_run_busy",    32'(bus.busy_o),   32'd1);
    bus.halted_i = 1'b0;
    tick();
    chk("rec1_idle_busy", 32'(bus.busy_o), 32'd0);

    // Back-to-back divergence; halted_i drops while x10 is being written.
    mis(1'b1, 5'd9, 32'h0000_9999, 32'h0000_9998, 32'h0000_0300);
    chk("b2b_halt", 32'(bus.halt_o),    32'd1);
    chk("b2b_err",  32'(bus.err_cnt_o), 32'd2);
    bus.halted_i = 1'b1;
    push_gprs(10);
    drain("part", 50);
    bus.halted_i = 1'b0;
    tick();
    chk("drop_halt",   32'(bus.halt_o),   32'd1);
    chk("drop_dbg_we", 32'(bus.dbg_we_o), 32'd0);
    chk("drop_busy",   32'(bus.busy_o),   32'd1);
    bus.halted_i = 1'b1;
    push_gprs(NREGS - 1);
    push_npc();
    drain("rec2", 200);
    tick();
    chk("rec2_resume", 32'(bus.resume_o), 32'd1);
    tick();
    bus.halted_i = 1'b0;
    tick();
    chk("rec2_idle_busy", 32'(bus.busy_o), 32'd0);

    // Halt never acknowledged: FATAL exactly 64 cycles after halt_o rises.
    mis(1'b1, 5'd3, 32'h0000_0001, 32'h0000_0002, 32'h0000_0400);
    chk("tmo_err", 32'(bus.err_cnt_o), 32'd3);
    repeat (63) tick();
    chk("tmo_pre_halt",  32'(bus.halt_o),      32'd1);
    chk("tmo_pre_fatal", 32'(bus.fatal_o),     32'd0);
    chk("tmo_pre_rst",   32'(bus.core_rst_no), 32'd1);
    tick();
    chk("tmo_fatal",    32'(bus.fatal_o),     32'd1);
    chk("tmo_core_rst", 32'(bus.core_rst_no), 32'd0);
    chk("tmo_halt_off", 32'(bus.halt_o),      32'd0);
    bus.halted_i = 1'b1;
    repeat (5) tick();
    chk("fatal_sticky", 32'(bus.fatal_o),     32'd1);
    chk("fatal_rst_lo", 32'(bus.core_rst_no), 32'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset("fatal_clear");

    // Fresh start after reset, then reset again in the middle of a GPR replay.
    bus.halted_i = 1'b0;
    model_clear();
    tick();
    rst_ni = 1'b1;
    tick();
    bus.we_a_i = 1'b1;  bus.we_b_i = 1'b0;
    bus.addr_a_i = 5'd4; bus.addr_b_i = 5'd4;
    bus.data_a_i = 32'h0000_0044; bus.data_b_i = 32'h0000_0044;
    tick();
    bus.we_a_i = 1'b0;
    chk("we_div_halt", 32'(bus.halt_o),    32'd1);
    chk("we_div_err",  32'(bus.err_cnt_o), 32'd1);
    bus.halted_i = 1'b1;
    tick();
    chk("lost_we",   32'(bus.dbg_we_o),    32'd1);
    chk("lost_addr", 32'(bus.dbg_addr_o),  32'h0000_0404);
    chk("lost_data", bus.dbg_wdata_o,      sh[1]);
    tick();
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset("mid_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
